// File: rtl/seq_alu.sv
// Registered multi-cycle ALU with START/BUSY/DONE handshake and full flag set.
// Single-cycle ops complete one edge after accept; MUL is a WIDTH-step shift-add.
`timescale 1ns/1ps

module seq_alu #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       SEL,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  output logic [WIDTH-1:0] OUT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             NEG,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MULT
  } state_e;

  typedef enum logic [2:0] {
    OP_MOV = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SRL = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [SHW-1:0]     count_q;

  logic [SHW-1:0]     amt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH:0]     sra_ext;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_carry;
  logic               exec_ovf;
  logic [2*WIDTH-1:0] prod_next;

  assign amt = b_q[SHW-1:0];

  // Shifts carry one guard bit so the last bit shifted out lands in a fixed
  // position; a zero shift amount leaves a zero there, giving CARRY=0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    exec_res   = '0;
    exec_carry = 1'b0;
    exec_ovf   = 1'b0;
    sum        = {1'b0, a_q} + {1'b0, b_q};
    shr_ext    = {a_q, 1'b0} >> amt;
    sra_ext    = $unsigned($signed({a_q, 1'b0}) >>> amt);
    shl_ext    = {1'b0, a_q} << amt;
    prod_next  = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (op_q)
      OP_MOV: exec_res = a_q;
      OP_ADD: begin
        exec_res   = sum[WIDTH-1:0];
        exec_carry = sum[WIDTH];
        exec_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_SRL: begin
        exec_res   = shr_ext[WIDTH:1];
        exec_carry = shr_ext[0];
      end
      OP_SLL: begin
        exec_res   = shl_ext[WIDTH-1:0];
        exec_carry = shl_ext[WIDTH];
      end
      OP_SRA: begin
        exec_res   = sra_ext[WIDTH:1];
        exec_carry = sra_ext[0];
      end
      default: exec_res = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: operand latches are reset too, so an aborted op leaves no stale state behind.
      state_q  <= S_IDLE;
      op_q     <= OP_MOV;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      OUT      <= '0;
      ZERO     <= 1'b1;
      CARRY    <= 1'b0;
      NEG      <= 1'b0;
      OVF      <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
      DONE <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            op_q <= op_e'(SEL);
            a_q  <= IN1;
            b_q  <= IN2;
            BUSY <= 1'b1;
            if (SEL == OP_MUL) begin
              mcand_q  <= {{WIDTH{1'b0}}, IN1};
              mplier_q <= IN2;
              acc_q    <= '0;
              count_q  <= '0;
              state_q  <= S_MULT;
            end else begin
              state_q  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          OUT     <= exec_res;
          ZERO    <= ~|exec_res;
          NEG     <= exec_res[WIDTH-1];
          CARRY   <= exec_carry;
          OVF     <= exec_ovf;
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          state_q <= S_IDLE;
        end
        S_MULT: begin
          acc_q    <= prod_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          if (count_q == LAST_STEP) begin
            OUT     <= prod_next[WIDTH-1:0];
            ZERO    <= ~|prod_next[WIDTH-1:0];
            NEG     <= prod_next[WIDTH-1];
            CARRY   <= 1'b0;
            OVF     <= |prod_next[2*WIDTH-1:WIDTH];
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=8 and WIDTH=16: vector table feeds a
// scoreboard queue per instance; hand sequences cover pulse width, chaining and reset.
`timescale 1ns/1ps

module tb_seq_alu;

  localparam logic [2:0] MOV = 3'b000, ADD = 3'b001, AND = 3'b010, OR = 3'b011;
  localparam logic [2:0] SRL = 3'b100, SLL = 3'b101, SRA = 3'b110, MUL = 3'b111;
  localparam int NVEC = 31;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, zero8, carry8, neg8, ovf8, busy8, done8;
  logic [2:0] sel8;
  logic [7:0] in1_8, in2_8, out8;

  logic        start16, zero16, carry16, neg16, ovf16, busy16, done16;
  logic [2:0]  sel16;
  logic [15:0] in1_16, in2_16, out16;

  seq_alu #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET_N(rst_n), .START(start8), .SEL(sel8), .IN1(in1_8), .IN2(in2_8),
    .OUT(out8), .ZERO(zero8), .CARRY(carry8), .NEG(neg8), .OVF(ovf8),
    .BUSY(busy8), .DONE(done8)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .CLK(clk), .RESET_N(rst_n), .START(start16), .SEL(sel16), .IN1(in1_16), .IN2(in2_16),
    .OUT(out16), .ZERO(zero16), .CARRY(carry16), .NEG(neg16), .OVF(ovf16),
    .BUSY(busy16), .DONE(done16)
  );

  // flags packed as {ZERO, CARRY, NEG, OVF}
  typedef struct {
    bit          w16;
    logic [2:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] out;
    logic [3:0]  f;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t q8 [$];
  exp_t q16 [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input int i, input bit w, input logic [2:0] s, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] o, input logic [3:0] f);
    vecs[i] = '{w, s, a, b, o, f};
  endtask

  // Scoreboards: pop the oldest expected result on each completion pulse.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) check("dut8 unexpected DONE", 16'd1, 16'd0);
      else begin
        e = q8.pop_front();
        check($sformatf("v%0d out", e.id), 16'(out8), e.out);
        check($sformatf("v%0d flags", e.id), 16'({zero8, carry8, neg8, ovf8}), 16'(e.f));
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16) begin
      if (q16.size() == 0) check("dut16 unexpected DONE", 16'd1, 16'd0);
      else begin
        e = q16.pop_front();
        check($sformatf("v%0d out", e.id), out16, e.out);
        check($sformatf("v%0d flags", e.id), 16'({zero16, carry16, neg16, ovf16}), 16'(e.f));
      end
    end
  end

  // Called just after a negedge with the DUT idle or in its DONE cycle;
  // returns at the negedge where DONE is observed.
  task automatic run(input int id);
    vec_t v;
    exp_t e;
    int   lat;
    int   exp_lat;
    bit   seen;
    logic d;
    v    = vecs[id];
    e.id = id;
    e.out = v.out;
    e.f  = v.f;
    if (v.w16) begin
      q16.push_back(e);
      start16 = 1'b1; sel16 = v.sel; in1_16 = v.a; in2_16 = v.b;
    end else begin
      q8.push_back(e);
      start8 = 1'b1; sel8 = v.sel; in1_8 = v.a[7:0]; in2_8 = v.b[7:0];
    end
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    in1_8 = 8'($urandom); in2_8 = 8'($urandom);
    in1_16 = 16'($urandom); in2_16 = 16'($urandom);
    check($sformatf("v%0d busy after accept", id), 16'(v.w16 ? busy16 : busy8), 16'd1);
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      if (v.sel == MUL && i == 3) begin
        if (v.w16) start16 = 1'b1; else start8 = 1'b1;
        in1_8 = 8'($urandom); in2_8 = 8'($urandom);
        in1_16 = 16'($urandom); in2_16 = 16'($urandom);
      end
      if (i == 4) begin
        start8 = 1'b0;
        start16 = 1'b0;
      end
      @(negedge clk);
      d = v.w16 ? done16 : done8;
      if (d) begin
        seen = 1'b1;
        lat = i;
      end
    end
    exp_lat = (v.sel == MUL) ? (v.w16 ? 16 : 8) : 1;
    if (!seen) begin
      check($sformatf("v%0d DONE timeout", id), 16'd0, 16'd1);
      if (v.w16) void'(q16.pop_back()); else void'(q8.pop_back());
    end else begin
      check($sformatf("v%0d latency", id), 16'(lat), 16'(exp_lat));
      check($sformatf("v%0d busy at done", id), 16'(v.w16 ? busy16 : busy8), 16'd0);
    end
  endtask

  initial begin
    //       id  w16  sel  a         b         out       ZCNV
    put( 0, 1'b0, ADD, 16'h00F0, 16'h0020, 16'h0010, 4'b0100);
    put( 1, 1'b0, ADD, 16'h007F, 16'h0001, 16'h0080, 4'b0011);
    put( 2, 1'b0, MOV, 16'h0000, 16'h0055, 16'h0000, 4'b1000);
    put( 3, 1'b0, SRL, 16'h0081, 16'h0001, 16'h0040, 4'b0100);
    put( 4, 1'b0, SRA, 16'h0090, 16'h0003, 16'h00F2, 4'b0010);
    put( 5, 1'b0, SLL, 16'h00C0, 16'h0002, 16'h0000, 4'b1100);
    put( 6, 1'b0, SRL, 16'h005A, 16'h0000, 16'h005A, 4'b0000);
    put( 7, 1'b0, AND, 16'h00F0, 16'h003C, 16'h0030, 4'b0000);
    put( 8, 1'b0, OR,  16'h00F0, 16'h000C, 16'h00FC, 4'b0010);
    put( 9, 1'b0, SLL, 16'h0081, 16'h0009, 16'h0002, 4'b0100);
    put(10, 1'b0, ADD, 16'h0080, 16'h0080, 16'h0000, 4'b1101);
    put(11, 1'b0, SRA, 16'h007F, 16'h0007, 16'h0000, 4'b1100);
    put(12, 1'b0, SRL, 16'h0080, 16'h0007, 16'h0001, 4'b0000);
    put(13, 1'b0, ADD, 16'h00FF, 16'h0001, 16'h0000, 4'b1100);
    put(14, 1'b0, MUL, 16'h000D, 16'h000B, 16'h008F, 4'b0010);
    put(15, 1'b0, MUL, 16'h0010, 16'h0010, 16'h0000, 4'b1001);
    put(16, 1'b0, MUL, 16'h00FF, 16'h00FF, 16'h0001, 4'b0001);
    put(17, 1'b0, AND, 16'h00F0, 16'h003C, 16'h0030, 4'b0000);
    put(18, 1'b0, ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0000);
    put(19, 1'b0, ADD, 16'h0001, 16'h0001, 16'h0002, 4'b0000);
    put(20, 1'b1, ADD, 16'hF000, 16'h2000, 16'h1000, 4'b0100);
    put(21, 1'b1, ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011);
    put(22, 1'b1, SRL, 16'h8001, 16'h0001, 16'h4000, 4'b0100);
    put(23, 1'b1, SRA, 16'h9000, 16'h0003, 16'hF200, 4'b0010);
    put(24, 1'b1, SLL, 16'hC000, 16'h0002, 16'h0000, 4'b1100);
    put(25, 1'b1, SRL, 16'h5A5A, 16'h0000, 16'h5A5A, 4'b0000);
    put(26, 1'b1, SRA, 16'h8000, 16'h000F, 16'hFFFF, 4'b0010);
    put(27, 1'b1, SLL, 16'h0001, 16'h000F, 16'h8000, 4'b0010);
    put(28, 1'b1, MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1001);
    put(29, 1'b1, MUL, 16'h00FF, 16'h0101, 16'hFFFF, 4'b0010);
    put(30, 1'b1, SLL, 16'h0003, 16'h0011, 16'h0006, 4'b0000);

    rst_n = 1'b0;
    start8 = 1'b0; sel8 = 3'b000; in1_8 = '0; in2_8 = '0;
    start16 = 1'b0; sel16 = 3'b000; in1_16 = '0; in2_16 = '0;
    repeat (2) @(negedge clk);
    check("reset dut8 out", 16'(out8), 16'h0000);
    check("reset dut8 zcnv/busy/done", 16'({zero8, carry8, neg8, ovf8, busy8, done8}), 16'b100000);
    check("reset dut16 out", out16, 16'h0000);
    check("reset dut16 zcnv/busy/done", 16'({zero16, carry16, neg16, ovf16, busy16, done16}), 16'b100000);
    rst_n = 1'b1;
    @(negedge clk);

    run(0);
    @(negedge clk);
    check("DONE pulse width", 16'(done8), 16'd0);
    check("idle after DONE", 16'(busy8), 16'd0);
    check("OUT holds after DONE", 16'(out8), 16'h0010);

    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      run(i);
    end

    // AND then ADD requested in the AND's DONE cycle
    @(negedge clk);
    run(17);
    run(18);

    // Abort a multiply partway through with an asynchronous reset.
    @(negedge clk);
    start8 = 1'b1; sel8 = MUL; in1_8 = 8'hFF; in2_8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-MUL reset out", 16'(out8), 16'h0000);
    check("mid-MUL reset zcnv/busy/done", 16'({zero8, carry8, neg8, ovf8, busy8, done8}), 16'b100000);
    repeat (10) @(negedge clk);
    check("no DONE during reset", 16'(done8), 16'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no DONE after aborted MUL", 16'(done8), 16'd0);
    check("OUT keeps reset value", 16'(out8), 16'h0000);
    run(19);

    for (int i = 20; i < NVEC; i++) begin
      @(negedge clk);
      run(i);
    end

    repeat (3) @(negedge clk);
    check("dut8 scoreboard drained", 16'(q8.size()), 16'd0);
    check("dut16 scoreboard drained", 16'(q16.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered, multi-cycle successor to the CPU's 8-bit combinational ALU.
- Same opcode encoding for MOV/ADD/AND/OR/SRL. Adds SLL, SRA and an iterative unsigned multiply.
- Adds a full flag set (ZERO, CARRY, NEG, OVF) and a START/BUSY/DONE handshake, so the CPU control unit can stall on long operations.
- Sits between the register file read ports and the writeback mux. WIDTH=8 drops into the current CPU.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a power of 2 and >= 4.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only while BUSY=0.
- SEL  input  3  opcode: 000 MOV, 001 ADD, 010 AND, 011 OR, 100 SRL, 101 SLL, 110 SRA, 111 MUL.
- IN1  input  WIDTH  operand A; the value to be shifted for shift ops.
- IN2  input  WIDTH  operand B; IN2[SHW-1:0] is the shift amount, upper bits ignored for shifts.
- OUT  output  WIDTH  registered result; holds until the next completion.
- ZERO  output  1  OUT == 0.
- CARRY  output  1  carry/shift-out flag.
- NEG  output  1  OUT[WIDTH-1].
- OVF  output  1  signed overflow (ADD) or product overflow (MUL).
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, RESET_N=0):
  - OUT=0, ZERO=1, CARRY=0, NEG=0, OVF=0, BUSY=0, DONE=0.
  - State=IDLE; multiply counter and accumulator cleared.
  - Reset mid-operation aborts it: no DONE, OUT keeps its reset value.
- States: IDLE, EXEC, MULT.
- BUSY=1 in EXEC and MULT, 0 in IDLE.
- IDLE accepts START=1 at edge N:
  - latch SEL, IN1, IN2;
  - go to EXEC if SEL!=111, else go to MULT with count=0.
- START while BUSY=1 is ignored. Operands may change freely after the accept edge.
- EXEC:
  - at edge N+1, compute from latched operands, update OUT and flags, assert DONE, return to IDLE.
  - Latency is 1 cycle after accept.
- MULT:
  - shift-add over WIDTH iterations, one iteration per edge;
  - at edge N+WIDTH, OUT = low WIDTH bits of the 2*WIDTH product, flags update, DONE asserts, return to IDLE.
- DONE is high exactly one cycle, coincident with state=IDLE. A START in that same cycle is accepted, giving back-to-back operation.
- OUT and flags change only at completion edges or reset; they hold otherwise.
- Arithmetic rules:
  - MOV: OUT=IN1.
  - ADD: OUT = IN1+IN2 mod 2^WIDTH. Subtraction is ADD with a two's-complemented IN2 supplied by the caller.
  - AND/OR: bitwise.
  - SRL: logical right shift; vacated bits 0.
  - SLL: logical left shift.
  - SRA: right shift replicating IN1[WIDTH-1].
  - Shift amount 0: OUT=IN1, CARRY=0.
  - MUL: unsigned.
- Flags:
  - ZERO = ~|OUT.
  - NEG = OUT[WIDTH-1].
  - CARRY:
    - ADD: carry out of the MSB.
    - SRL/SRA: last bit shifted out, IN1[amt-1].
    - SLL: last bit shifted out, IN1[WIDTH-amt].
    - all other ops: 0.
  - OVF:
    - ADD: operands have the same sign and the result sign differs.
    - MUL: upper WIDTH bits of the product are nonzero.
    - all other ops: 0.
- An unknown SEL cannot occur (all 8 codes are defined).

Test Plan:
- Reset, then ADD 0xF0+0x20: OUT=0x10, CARRY=1, OVF=0, ZERO=0. DONE high exactly 1 cycle, one edge after the accept edge; BUSY high for 1 cycle.
- ADD 0x7F+0x01 -> OUT=0x80, NEG=1, OVF=1, CARRY=0. Then MOV 0x00 -> OUT=0x00, ZERO=1, NEG=0, OVF=0.
- Shifts:
  - SRL 0x81 by 1 -> 0x40, CARRY=1.
  - SRA 0x90 by 3 -> 0xF2, CARRY=0, NEG=1.
  - SLL 0xC0 by 2 -> 0x00, CARRY=1, ZERO=1.
  - SRL 0x5A by 0 -> 0x5A, CARRY=0.
- MUL 13*11 -> OUT=0x8F, OVF=0, DONE at edge N+8. Pulse START and change IN1/IN2 during BUSY: no effect on the result. MUL 0x10*0x10 -> OUT=0x00, ZERO=1, OVF=1.
- Back-to-back: assert START with ADD 1+2 in the DONE cycle of a prior AND -> accepted, OUT=0x03 one edge later. No DONE gap is missed, no request is lost.
- Reset mid-MUL: assert RESET_N=0 asynchronously 4 cycles into MUL 0xFF*0xFF -> all outputs reset immediately, no DONE. After release, ADD 0x01+0x01 -> OUT=0x02. Repeat ADD/SHIFT cases at WIDTH=16.
